// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the PC generator.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    ERET,
    EXC
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating count.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             valid
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    tp;
  logic [PW-1:0]    tp_inc;
  logic [PW-1:0]    tp_dec;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;

  // Push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    empty   = (cnt == '0);
    tp_inc  = tp + 1'b1;
    tp_dec  = tp - 1'b1;
    do_repl = !reset && en && push && pop && !empty;
    do_push = !reset && en && push && !(pop && !empty);
    do_pop  = !reset && en && pop && !push && !empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      tp <= tp_inc;
      if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + 1'b1;
    end else if (do_pop) begin
      tp  <= tp_dec;
      cnt <= cnt - 1'b1;
    end
  end

  // Entries are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push)      mem[tp_inc] <= din;
    else if (do_repl) mem[tp]     <= din;
  end

  assign top   = mem[tp];
  assign valid = !empty;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: prioritised next-PC mux, alignment trap and RAS.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_q = RESET_VEC;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] target;
  logic             mis_next;
  logic             bad_align;
  pc_sel_e          sel;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    sel    = SEQ;
    target = pc_plus4;
    if (exc_req) begin
      sel = EXC;
    end else if (eret) begin
      sel    = ERET;
      target = epc_in;
    end else if (jump) begin
      sel    = JMP;
      target = jump_target;
    end else if (br_taken) begin
      sel    = BR;
      target = br_target;
    end
  end

  // Exceptions bypass the stall; everything else only moves when pc_en is high.
  always_comb begin
    bad_align = (sel == ERET || sel == JMP || sel == BR) && (target[1:0] != 2'b00);
    pc_next   = pc_q;
    mis_next  = 1'b0;
    if (sel == EXC) begin
      pc_next = EXC_VEC;
    end else if (pc_en) begin
      if (bad_align) begin
        pc_next  = EXC_VEC;
        mis_next = 1'b1;
      end else begin
        pc_next = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      misalign <= mis_next;
    end
  end

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .reset(reset),
    .push (ras_push),
    .pop  (ras_pop),
    .en   (pc_en && !exc_req),
    .din  (pc_q + WIDTH'(8)),
    .top  (ras_top),
    .valid(ras_valid)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, pc_en, br_taken, jump, exc_req, eret, ras_push, ras_pop;
  logic [31:0] br_target, jump_target, epc_in;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .RAS_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_en      (pc_en),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jump_target(jump_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc_in     (epc_in),
    .ras_push   (ras_push),
    .ras_pop    (ras_pop),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ras_top    (ras_top),
    .ras_valid  (ras_valid),
    .misalign   (misalign)
  );

  typedef struct {
    logic        rst, en, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc, ert;
    logic [31:0] epc;
    logic        psh, pp;
    logic [31:0] e_pc;
    logic        e_mis, e_val;
    logic [31:0] e_top;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic en, logic br, logic [31:0] brt,
                              logic jmp, logic [31:0] jt, logic exc, logic ert,
                              logic [31:0] epc, logic psh, logic pp,
                              logic [31:0] e_pc, logic e_mis, logic e_val,
                              logic [31:0] e_top);
    vec_t v;
    v.rst = rst; v.en = en; v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt;
    v.exc = exc; v.ert = ert; v.epc = epc; v.psh = psh; v.pp = pp;
    v.e_pc = e_pc; v.e_mis = e_mis; v.e_val = e_val; v.e_top = e_top;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; pc_en = v.en; br_taken = v.br; br_target = v.brt;
    jump = v.jmp; jump_target = v.jt; exc_req = v.exc; eret = v.ert;
    epc_in = v.epc; ras_push = v.psh; ras_pop = v.pp;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    idle();
    #1;
    check("init_pc", pc, 32'h3000);

    //     rst en br brt          jmp jt           exc ert epc          psh pp  e_pc         mis val top
    vq.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3000,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3004,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3008,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h300C,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3010,     0, 0, 0));
    vq.push_back(mk(0, 0, 1, 32'h3040,     0, 0,            0, 0, 0,            0, 0, 32'h3010,     0, 0, 0));
    vq.push_back(mk(0, 0, 1, 32'h3040,     0, 0,            0, 0, 0,            0, 0, 32'h3010,     0, 0, 0));
    vq.push_back(mk(0, 1, 1, 32'h3040,     0, 0,            0, 0, 0,            0, 0, 32'h3040,     0, 0, 0));
    vq.push_back(mk(0, 0, 1, 32'h3040,     1, 32'h3100,     1, 0, 0,            1, 0, 32'h4180,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            1, 32'h3102,     0, 0, 0,            0, 0, 32'h4180,     1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 1, 32'h3100,     0, 0, 32'h3100,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3104,     0, 0, 0));
    // RAS fill past depth, then drain past empty
    vq.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3000,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h3004,     0, 1, 32'h3008));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h3008,     0, 1, 32'h300C));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h300C,     0, 1, 32'h3010));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h3010,     0, 1, 32'h3014));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h3014,     0, 1, 32'h3018));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h3018,     0, 1, 32'h3014));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h301C,     0, 1, 32'h3010));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h3020,     0, 1, 32'h300C));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h3024,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h3028,     0, 0, 0));
    // push+pop replaces top without changing count
    vq.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3000,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3004,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3008,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h300C,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3010,     0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h3014,     0, 1, 32'h3018));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3018,     0, 1, 32'h3018));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h301C,     0, 1, 32'h3018));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h3020,     0, 1, 32'h3018));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 1, 32'h3024,     0, 1, 32'h3028));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            0, 1, 32'h3028,     0, 0, 0));
    // exc_req leaves a non-empty RAS alone; reset beats exc_req
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h302C,     0, 1, 32'h3030));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            1, 0, 0,            0, 1, 32'h4180,     0, 1, 32'h3030));
    vq.push_back(mk(1, 1, 0, 0,            0, 0,            1, 0, 0,            1, 0, 32'h3000,     0, 0, 0));
    // wrap of pc+4 and pc+8, then misaligned branch / eret and stalled jump
    vq.push_back(mk(0, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0,           0, 0, 32'hFFFF_FFFC, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0,            1, 0, 32'h0000_0000, 0, 1, 32'h4));
    vq.push_back(mk(0, 1, 1, 32'h3001,     0, 0,            0, 0, 0,            0, 0, 32'h4180,     1, 1, 32'h4));
    vq.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0,            0, 0, 32'h4180,     0, 1, 32'h4));
    vq.push_back(mk(0, 1, 0, 0,            0, 0,            0, 1, 32'h3102,     0, 0, 32'h4180,     1, 1, 32'h4));
    vq.push_back(mk(0, 0, 0, 0,            1, 32'h3102,     0, 0, 0,            0, 0, 32'h4180,     0, 1, 32'h4));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
      check($sformatf("v%0d_pc4", i), pc_plus4, vq[i].e_pc + 32'd4);
      check($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vq[i].e_mis});
      check($sformatf("v%0d_val", i), {31'b0, ras_valid}, {31'b0, vq[i].e_val});
      if (vq[i].e_val) check($sformatf("v%0d_top", i), ras_top, vq[i].e_top);
    end

    // Exception held across a stall: pc parks on the handler, no misalign pulse.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("seq_rst_pc", pc, 32'h3000);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("seq_exc%0d_pc", k), pc, 32'h4180);
      check($sformatf("seq_exc%0d_mis", k), {31'b0, misalign}, 32'h0);
    end

    // Misalign pulse lasts one cycle even if the request is held under stall.
    drive(mk(0, 1, 0, 0, 1, 32'h3006, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("seq_mis_pc", pc, 32'h4180);
    check("seq_mis_on", {31'b0, misalign}, 32'h1);
    pc_en = 1'b0;
    @(posedge clk); #1;
    check("seq_mis_off", {31'b0, misalign}, 32'h0);
    check("seq_mis_hold", pc, 32'h4180);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - WIDTH, 32, address width.
  - RESET_VEC, 32'h0000_3000, PC value after reset.
  - EXC_VEC, 32'h0000_4180, exception handler entry.
  - RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2).
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, clock; all state updates on its rising edge.
  - reset, in, 1, synchronous, active-high.
  - pc_en, in, 1, 1 = advance PC; 0 = stall (hold).
  - br_taken, in, 1, take br_target.
  - br_target, in, WIDTH, branch destination.
  - jump, in, 1, take jump_target.
  - jump_target, in, WIDTH, jump/jr destination.
  - exc_req, in, 1, exception request.
  - eret, in, 1, return from exception.
  - epc_in, in, WIDTH, eret destination.
  - ras_push, in, 1, push pc+8 (jal).
  - ras_pop, in, 1, pop stack (jr $ra).
  - pc, out, WIDTH, current PC (registered).
  - pc_plus4, out, WIDTH, pc+4 (combinational).
  - ras_top, out, WIDTH, top stack entry.
  - ras_valid, out, 1, stack non-empty.
  - misalign, out, 1, registered one-cycle pulse: misaligned redirect trapped.

Function
REQ-003 Next-PC priority, highest first: reset > exc_req > eret > jump > br_taken > pc+4.
REQ-004 exc_req SHALL load EXC_VEC on the next edge regardless of pc_en.
REQ-005 eret, jump, br_taken and sequential advance SHALL take effect only when pc_en=1; when pc_en=0, pc holds.
REQ-006 A selected redirect target (eret/jump/branch) with bits [1:0] != 0 SHALL instead load EXC_VEC and set misalign=1 for exactly one cycle.
REQ-007 misalign SHALL be 0 in every other cycle, including exc_req cycles.
REQ-008 Arithmetic SHALL be modulo 2^WIDTH: pc+4 and pc+8 wrap without a flag.
REQ-009 RAS is a circular buffer: top pointer plus count, count saturating at RAS_DEPTH; updates only when pc_en=1.
REQ-010 Push SHALL write pc+8 above the top and increment count. When full, the top pointer wraps and overwrites the oldest entry; count stays RAS_DEPTH.
REQ-011 Pop SHALL decrement the top pointer and count. Pop when empty SHALL change nothing.
REQ-012 Push and pop in the same cycle SHALL replace the top entry with pc+8; count is unchanged (if empty, this behaves as a push).
REQ-013 ras_top SHALL show the entry at the top pointer combinationally; ras_valid = (count != 0). ras_top is don't-care when ras_valid=0.
REQ-014 exc_req SHALL NOT modify the RAS even if ras_push or ras_pop is asserted.

Reset
REQ-015 On reset: pc = RESET_VEC, count = 0, top pointer = 0, misalign = 0, ras_valid = 0.
REQ-016 Stack contents SHALL NOT be cleared by reset.
REQ-017 Reset SHALL win over every simultaneous request, including exc_req.
REQ-018 Simulation initial value of pc SHALL equal RESET_VEC.

Structure
REQ-019 A shared package pc_pkg SHALL hold the defaults for RESET_VEC and EXC_VEC and the next-PC select encoding (SEQ, BR, JMP, ERET, EXC).
REQ-020 The stack SHALL be one sub-module, pc_ras (parameters WIDTH and RAS_DEPTH; ports push, pop, en, din, top, valid).
REQ-021 The next-PC mux and alignment check SHALL live in pc_gen.

Verification
REQ-022 Reset then 3 cycles with pc_en=1 -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-023 pc_en=0 for 2 cycles at pc=0x3010 with br_taken=1 -> pc stays 0x3010; when pc_en rises, pc = br_target.
REQ-024 jump=1 (jump_target=0x3100), br_taken=1 and exc_req=1 in the same cycle, pc_en=0 -> pc = 0x4180, misalign = 0, RAS unchanged.
REQ-025 jump_target=0x3102, pc_en=1 -> pc = 0x4180 and misalign=1 for exactly one cycle. Next, eret with epc_in=0x3100 -> pc = 0x3100.
REQ-026 RAS_DEPTH=4: five pushes at pc=0x3000, 0x3004, 0x3008, 0x300C, 0x3010 -> ras_top = 0x3018. Four pops -> tops read 0x3014, 0x3010, 0x300C, then ras_valid = 0. A fifth pop changes nothing.
REQ-027 Push and pop together at pc=0x3020 with ras_top=0x3018 -> ras_top = 0x3028, count unchanged. Reset mid-sequence -> ras_valid = 0, pc = 0x3000.
